// File: rtl/xup_mux_scan_controller.sv
// xup_mux_scan_controller
// Round-robin select sequencer for a 4-to-1 vector mux. It drives `sel`
// across the enabled channels and waits DWELL cycles for the mux output to
// settle. It then captures the mux output with its channel number and offers
// the sample downstream on a valid/ready handshake. Scanning stalls while a
// sample is unconsumed, so no sample is ever dropped or overwritten.
module xup_mux_scan_controller #(
  parameter int SIZE  = 8,
  parameter int DWELL = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [3:0]      ch_en,
  input  logic [SIZE-1:0] mux_y,
  output logic [1:0]      sel,
  output logic [SIZE-1:0] data_out,
  output logic [1:0]      ch_out,
  output logic            valid,
  input  logic            ready,
  output logic            busy
);

  // Counter wide enough for DWELL-1; DWELL=1 still needs a one-bit counter.
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Reject an out-of-range settle time when the design is elaborated.
  if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
    $error("DWELL must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // waiting for run with at least one channel enabled
    SETTLE = 2'd1,  // sel driven, counting down the mux settle time
    HOLD   = 2'd2   // sample captured, waiting for ready
  } state_e;

  // First enabled channel at or above `start`, wrapping 3->0. Searching from
  // the farthest offset down lets the nearest hit overwrite the others, so
  // no extra found flag is needed. If no channel is enabled, `start` is kept.
  function automatic logic [1:0] next_ch(input logic [1:0] start,
                                         input logic [3:0] en);
    logic [1:0] result;
    logic [1:0] idx;
    result = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (en[idx]) result = idx;
    end
    return result;
  endfunction

  state_e            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SIZE-1:0]   data_q, data_d;
  logic [1:0]        ch_q, ch_d;
  logic              valid_q, valid_d;
  logic              can_start;

  // Channel selection happens only when run is high and something is enabled.
  assign can_start = run && (ch_en != 4'b0000);

  // Next-state, select, counter and capture logic for the scan FSM.
  always_comb begin
    // NOTE: every signal gets a default first, so a path that doesn't assign
    // it holds the register value instead of inferring a latch.
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;

    unique case (state_q)
      IDLE: begin
        if (can_start) begin
          sel_d   = next_ch(ptr_q, ch_en);
          cnt_d   = CNT_LOAD;
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        if (cnt_q == '0) begin
          data_d  = mux_y;
          ch_d    = sel_q;
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      HOLD: begin
        // Everything stays frozen until the sample is taken.
        if (valid_q && ready) begin
          valid_d = 1'b0;
          ptr_d   = sel_q + 2'd1;
          if (can_start) begin
            sel_d   = next_ch(sel_q + 2'd1, ch_en);
            cnt_d   = CNT_LOAD;
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset clears everything, including any pending sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      data_q  <= '0;
      ch_q    <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so all registers update from the
      // values held before this edge, whatever the statement order.
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
    end
  end

  assign sel      = sel_q;
  assign data_out = data_q;
  assign ch_out   = ch_q;
  assign valid    = valid_q;
  assign busy     = (state_q != IDLE);

  // An unconsumed sample and the select lines stay frozen while stalled.
  a_hold_stable: assert property (@(posedge clk) disable iff (reset)
    (valid && !ready) |=> (valid && $stable(data_out) && $stable(ch_out) && $stable(sel)));

  // A sample is only presented while the sequencer is active.
  a_valid_busy: assert property (@(posedge clk) disable iff (reset)
    valid |-> busy);

endmodule

// File: tb/tb_xup_mux_scan_controller.sv
// Self-checking bench for xup_mux_scan_controller. It combines a fixed
// vector table for the basic scan, hand-written corner-case sequences, and
// a randomized phase. A timestamp-based reference model is compared on
// every clock edge.
module tb_xup_mux_scan_controller;

  localparam int SIZE  = 8;
  localparam int DWELL = 4;

  logic            clk;
  logic            reset;
  logic            run;
  logic [3:0]      ch_en;
  logic [SIZE-1:0] mux_y;
  logic [1:0]      sel;
  logic [SIZE-1:0] data_out;
  logic [1:0]      ch_out;
  logic            valid;
  logic            ready;
  logic            busy;

  // Behavioural 4-to-1 mux in front of the DUT, with an override for tests
  // that need to change the mux output while it settles.
  logic [SIZE-1:0] mux_in [4];
  logic            ovr_en;
  logic [SIZE-1:0] ovr_val;
  assign mux_y = ovr_en ? ovr_val : mux_in[sel];

  xup_mux_scan_controller #(.SIZE(SIZE), .DWELL(DWELL)) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .ch_en    (ch_en),
    .mux_y    (mux_y),
    .sel      (sel),
    .data_out (data_out),
    .ch_out   (ch_out),
    .valid    (valid),
    .ready    (ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model. It tracks whether a channel is selected, when its
  // capture is due (as an absolute edge number), and the pending sample.
  int              m_cyc, m_cap, m_sel, m_ptr, m_ch;
  bit              m_busy, m_valid;
  logic [SIZE-1:0] m_data;

  function automatic int pick(input int start, input logic [3:0] en);
    for (int k = 0; k < 4; k++)
      if (en[(start + k) % 4]) return (start + k) % 4;
    return start;
  endfunction

  task automatic model_reset();
    m_sel = 0; m_ptr = 0; m_ch = 0; m_cap = 0;
    m_busy = 1'b0; m_valid = 1'b0; m_data = '0;
  endtask

  task automatic model_edge(input logic r, input logic [3:0] e, input logic rd,
                            input logic [SIZE-1:0] y);
    m_cyc++;
    if (!m_busy) begin
      if (r && e != 4'b0) begin
        m_sel = pick(m_ptr, e); m_busy = 1'b1; m_cap = m_cyc + DWELL;
      end
    end else if (!m_valid) begin
      if (m_cyc == m_cap) begin
        m_data = y; m_ch = m_sel; m_valid = 1'b1;
      end
    end else if (rd) begin
      m_valid = 1'b0;
      m_ptr   = (m_sel + 1) % 4;
      if (r && e != 4'b0) begin
        m_sel = pick(m_ptr, e); m_cap = m_cyc + DWELL;
      end else begin
        m_busy = 1'b0;
      end
    end
  endtask

  function automatic logic [13:0] dut_pack();
    return {sel, valid, ch_out, data_out, busy};
  endfunction

  function automatic logic [13:0] model_pack();
    return {2'(m_sel), m_valid, 2'(m_ch), m_data, m_busy};
  endfunction

  // One clock edge: sample inputs as the DUT sees them, advance the model,
  // then compare outputs 1 ns after the edge.
  task automatic step();
    logic r, rd;
    logic [3:0] e;
    logic [SIZE-1:0] y;
    r = run; e = ch_en; rd = ready;
    y = ovr_en ? ovr_val : mux_in[m_sel];
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge(r, e, rd, y);
    #1;
    check("model", 64'(dut_pack()), 64'(model_pack()));
  endtask

  task automatic wait_valid(input int max_cycles);
    int n;
    n = 0;
    while (valid !== 1'b1 && n < max_cycles) begin
      step();
      n++;
    end
    check("wait_valid", 64'(valid), 64'd1);
  endtask

  typedef struct {
    logic       run;
    logic [3:0] en;
    logic       rdy;
    logic [1:0] sel;
    logic       vld;
    logic [1:0] ch;
    logic [7:0] data;
    logic       bsy;
  } vec_t;

  vec_t vecs [25];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int got [$];
    int n2;

    // Full scan with every channel enabled, ready always high: one sample
    // every DWELL+1 edges, channels 0,1,2,3,0.
    vecs[0]  = '{1'b1, 4'hF, 1'b1, 2'd0, 1'b0, 2'd0, 8'h00, 1'b1};
    vecs[1]  = '{1'b1, 4'hF, 1'b1, 2'd0, 1'b0, 2'd0, 8'h00, 1'b1};
    vecs[2]  = '{1'b1, 4'hF, 1'b1, 2'd0, 1'b0, 2'd0, 8'h00, 1'b1};
    vecs[3]  = '{1'b1, 4'hF, 1'b1, 2'd0, 1'b0, 2'd0, 8'h00, 1'b1};
    vecs[4]  = '{1'b1, 4'hF, 1'b1, 2'd0, 1'b1, 2'd0, 8'h11, 1'b1};
    vecs[5]  = '{1'b1, 4'hF, 1'b1, 2'd1, 1'b0, 2'd0, 8'h11, 1'b1};
    vecs[6]  = '{1'b1, 4'hF, 1'b1, 2'd1, 1'b0, 2'd0, 8'h11, 1'b1};
    vecs[7]  = '{1'b1, 4'hF, 1'b1, 2'd1, 1'b0, 2'd0, 8'h11, 1'b1};
    vecs[8]  = '{1'b1, 4'hF, 1'b1, 2'd1, 1'b0, 2'd0, 8'h11, 1'b1};
    vecs[9]  = '{1'b1, 4'hF, 1'b1, 2'd1, 1'b1, 2'd1, 8'h22, 1'b1};
    vecs[10] = '{1'b1, 4'hF, 1'b1, 2'd2, 1'b0, 2'd1, 8'h22, 1'b1};
    vecs[11] = '{1'b1, 4'hF, 1'b1, 2'd2, 1'b0, 2'd1, 8'h22, 1'b1};
    vecs[12] = '{1'b1, 4'hF, 1'b1, 2'd2, 1'b0, 2'd1, 8'h22, 1'b1};
    vecs[13] = '{1'b1, 4'hF, 1'b1, 2'd2, 1'b0, 2'd1, 8'h22, 1'b1};
    vecs[14] = '{1'b1, 4'hF, 1'b1, 2'd2, 1'b1, 2'd2, 8'h33, 1'b1};
    vecs[15] = '{1'b1, 4'hF, 1'b1, 2'd3, 1'b0, 2'd2, 8'h33, 1'b1};
    vecs[16] = '{1'b1, 4'hF, 1'b1, 2'd3, 1'b0, 2'd2, 8'h33, 1'b1};
    vecs[17] = '{1'b1, 4'hF, 1'b1, 2'd3, 1'b0, 2'd2, 8'h33, 1'b1};
    vecs[18] = '{1'b1, 4'hF, 1'b1, 2'd3, 1'b0, 2'd2, 8'h33, 1'b1};
    vecs[19] = '{1'b1, 4'hF, 1'b1, 2'd3, 1'b1, 2'd3, 8'h44, 1'b1};
    vecs[20] = '{1'b1, 4'hF, 1'b1, 2'd0, 1'b0, 2'd3, 8'h44, 1'b1};
    vecs[21] = '{1'b1, 4'hF, 1'b1, 2'd0, 1'b0, 2'd3, 8'h44, 1'b1};
    vecs[22] = '{1'b1, 4'hF, 1'b1, 2'd0, 1'b0, 2'd3, 8'h44, 1'b1};
    vecs[23] = '{1'b1, 4'hF, 1'b1, 2'd0, 1'b0, 2'd3, 8'h44, 1'b1};
    vecs[24] = '{1'b1, 4'hF, 1'b1, 2'd0, 1'b1, 2'd0, 8'h11, 1'b1};

    mux_in[0] = 8'h11; mux_in[1] = 8'h22; mux_in[2] = 8'h33; mux_in[3] = 8'h44;
    reset = 1'b1; run = 1'b0; ch_en = 4'b0; ready = 1'b0;
    ovr_en = 1'b0; ovr_val = '0;
    m_cyc = 0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 64'({sel, valid, ch_out, data_out, busy}), 64'd0);
    reset = 1'b0;

    // Vector table.
    for (int i = 0; i < 25; i++) begin
      run = vecs[i].run; ch_en = vecs[i].en; ready = vecs[i].rdy;
      step();
      check($sformatf("vec%0d", i),
            64'({sel, valid, ch_out, data_out, busy}),
            64'({vecs[i].sel, vecs[i].vld, vecs[i].ch, vecs[i].data, vecs[i].bsy}));
    end

    // Stalled ready freezes the held sample for 20 cycles.
    ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("stall_hold", 64'({sel, valid, ch_out, data_out}),
            64'({2'd0, 1'b1, 2'd0, 8'h11}));
    end
    ready = 1'b1;
    step();
    check("accept_edge", 64'({sel, valid}), 64'({2'd1, 1'b0}));
    for (int i = 0; i < DWELL - 1; i++) begin
      step();
      check("settle_wait", 64'(valid), 64'd0);
    end
    step();
    check("next_after_accept", 64'({valid, ch_out, data_out}), 64'({1'b1, 2'd1, 8'h22}));

    // Mux output changes while settling; run drops mid-sample.
    step();
    check("accept_to_ch2", 64'({sel, valid}), 64'({2'd2, 1'b0}));
    run = 1'b0; ready = 1'b0; ovr_en = 1'b1; ovr_val = 8'hAA;
    step(); step();
    ovr_val = 8'h77;
    step();
    ovr_val = 8'h5C;
    step();
    check("capture_at_edge", 64'({valid, ch_out, data_out}), 64'({1'b1, 2'd2, 8'h5C}));
    ready = 1'b1;
    step();
    check("run_drop_idle", 64'({valid, busy}), 64'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("stay_idle", 64'({valid, busy}), 64'd0);
    end
    ovr_en = 1'b0;

    // Asynchronous reset while a sample is held.
    run = 1'b1; ch_en = 4'hF; ready = 1'b0;
    wait_valid(20);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 64'({sel, valid, ch_out, data_out, busy}), 64'd0);
    step();
    reset = 1'b0; ch_en = 4'b1010; run = 1'b1; ready = 1'b1;

    // Alternating channels 1,3 starting from the lowest enabled one.
    for (int c = 0; c < 20; c++) begin
      step();
      if (busy) check("sel_1010", 64'(sel == 2'd1 || sel == 2'd3), 64'd1);
      if (valid) got.push_back(int'(ch_out));
    end
    check("n_1010", 64'(got.size()), 64'd4);
    for (int i = 0; i < got.size() && i < 4; i++)
      check($sformatf("ch_1010_%0d", i), 64'(got[i]), 64'((i % 2 == 0) ? 1 : 3));

    // No channel enabled: stay idle.
    ch_en = 4'b0000;
    step();
    check("en0_exit", 64'({valid, busy}), 64'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("en0_idle", 64'(busy), 64'd0);
    end

    // Single channel: repeated channel-2 samples, sel never moves.
    ch_en = 4'b0100;
    n2 = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      check("sel_stays_2", 64'(sel), 64'd2);
      if (valid && ch_out == 2'd2 && data_out == 8'h33) n2++;
    end
    check("n_ch2", 64'(n2), 64'd3);

    // Randomized phase against the model, with occasional async reset.
    for (int i = 0; i < 3000; i++) begin
      run   = ($urandom_range(0, 9) < 8);
      ch_en = ($urandom_range(0, 7) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) mux_in[$urandom_range(0, 3)] = 8'($urandom);
      step();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
